// File: rtl/ysyx_22040632_pipe_pkg.sv
// Shared pipeline types: stage payload structs, their widths for the slice DW,
// the NOP used for bubbles, and decode enums consumed by the datapath stages.
package ysyx_22040632_pipe_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [2:0] {
    LD_NONE, LD_LB, LD_LH, LD_LW, LD_LD, LD_LBU, LD_LHU, LD_LWU
  } ld_t;

  typedef enum logic [2:0] {
    SD_NONE, SD_SB, SD_SH, SD_SW, SD_SD
  } sd_t;

  typedef enum logic [3:0] {
    FN_ADD, FN_SUB, FN_SLL, FN_SLT, FN_SLTU, FN_XOR, FN_SRL, FN_SRA, FN_OR, FN_AND
  } func_t;

  // Slice occupancy states, encoded as {skid_v, main_v}.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_BUSY  = 2'b01,
    ST_FULL  = 2'b11
  } slice_st_e;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } if2id_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
    logic [63:0] rs1_val;
    logic [63:0] rs2_val;
    logic [63:0] imm;
    logic [4:0]  rd;
    func_t       func;
    ld_t         ld;
    sd_t         sd;
    logic        wen;
  } id2ex_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] alu_res;
    logic [63:0] store_val;
    logic [4:0]  rd;
    ld_t         ld;
    sd_t         sd;
    logic        wen;
  } ex2mem_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] wdata;
    logic [4:0]  rd;
    logic        wen;
  } mem2wb_t;

  localparam int IF2ID_W  = $bits(if2id_t);
  localparam int ID2EX_W  = $bits(id2ex_t);
  localparam int EX2MEM_W = $bits(ex2mem_t);
  localparam int MEM2WB_W = $bits(mem2wb_t);

  // Bubble for the fetch->decode slice: a NOP at pc 0.
  function automatic if2id_t if2id_bubble();
    if2id_t b;
    b.pc   = '0;
    b.inst = NOP_INST;
    return b;
  endfunction

endpackage

// File: rtl/ysyx_22040632_sat_cnt.sv
// Saturating up-counter with synchronous clear; shared by the perf counters.
module ysyx_22040632_sat_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/ysyx_22040632_pipe_slice.sv
// Parametrised pipeline-stage register with valid/ready handshake, flush,
// bubble output and optional 2-entry skid buffer (registered in_ready).
module ysyx_22040632_pipe_slice
  import ysyx_22040632_pipe_pkg::*;
#(
  parameter int              DW     = 64,
  parameter int              DEPTH  = 2,
  parameter logic [DW-1:0]   BUBBLE = '0,
  parameter int              CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  logic          main_v;
  logic          skid_v;
  logic [DW-1:0] main_q;
  logic [DW-1:0] skid_q;
  logic          in_fire;
  logic          out_fire;
  logic          stall_inc;
  slice_st_e     st;

  generate
    if (DEPTH != 1 && DEPTH != 2) begin : g_bad_depth
      $error("ysyx_22040632_pipe_slice: DEPTH must be 1 or 2");
    end
  endgenerate

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    st        = ST_EMPTY;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    occupancy = 2'd0;
    if (main_v) st = skid_v ? ST_FULL : ST_BUSY;
    if (!rst) begin
      // Skid mode breaks the out_ready->in_ready path; single mode passes it through.
      in_ready  = (DEPTH == 1) ? (!main_v || out_ready) : !skid_v;
      out_valid = main_v;
      occupancy = {1'b0, main_v} + {1'b0, skid_v};
    end
    out_data  = out_valid ? main_q : BUBBLE;
    in_fire   = in_valid && in_ready;
    out_fire  = out_valid && out_ready;
    stall_inc = out_valid && !out_ready;
  end

  // NOTE: only the valid bits are reset; payload registers are qualified by them.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (DEPTH == 1) begin
      if (in_fire) begin
        main_q <= in_data;
        main_v <= 1'b1;
      end else if (out_fire) begin
        main_v <= 1'b0;
      end
    end else begin
      unique case (st)
        ST_EMPTY: begin
          if (in_fire) begin
            main_q <= in_data;
            main_v <= 1'b1;
          end
        end
        ST_BUSY: begin
          if (in_fire && out_fire) begin
            main_q <= in_data;
          end else if (in_fire) begin
            skid_q <= in_data;
            skid_v <= 1'b1;
          end else if (out_fire) begin
            main_v <= 1'b0;
          end
        end
        ST_FULL: begin
          // Skid drains into main so ordering stays FIFO.
          if (out_fire) begin
            main_q <= skid_q;
            skid_v <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  ysyx_22040632_sat_cnt #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk(clk),
    .clr(rst),
    .inc(stall_inc),
    .cnt(stall_cnt)
  );

  property p_hold_while_stalled;
    @(posedge clk) disable iff (rst)
      (out_valid && !out_ready && !flush) |=> ((out_valid && $stable(out_data)) || rst);
  endproperty

  a_hold_while_stalled: assert property (p_hold_while_stalled)
    else $error("out_valid/out_data changed while stalled without flush");

endmodule

// File: tb/tb_ysyx_22040632_pipe_slice.sv
// Bench for ysyx_22040632_pipe_slice: three configurations checked against a
// queue-based reference model plus scenario-specific expectations.
`timescale 1ns/1ps
module tb_ysyx_22040632_pipe_slice;
  import ysyx_22040632_pipe_pkg::*;

  localparam int          N   = 3;
  localparam logic [63:0] BUB = {32'h0, NOP_INST};
  localparam logic [63:0] VA  = 64'hA;
  localparam logic [63:0] VB  = 64'hB;
  localparam logic [63:0] VC  = 64'hC;
  localparam logic [63:0] VD  = 64'hD;

  typedef struct packed {
    logic        ir;
    logic        ov;
    logic [63:0] od;
    logic [1:0]  occ;
    logic [31:0] sc;
  } view_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]       rst, flush, in_valid, out_ready;
  logic [N-1:0][63:0] in_data;
  wire  [N-1:0]       in_ready, out_valid;
  wire  [N-1:0][63:0] out_data;
  wire  [N-1:0][1:0]  occupancy;
  wire  [31:0]        sc0;
  wire  [3:0]         sc1;
  wire  [7:0]         sc2;

  // Unit 0: skid, NOP bubble. Unit 1: skid, 4-bit counter. Unit 2: single register.
  ysyx_22040632_pipe_slice #(.DW(64), .DEPTH(2), .BUBBLE(BUB), .CNT_W(32)) u_skid (
    .clk(clk), .rst(rst[0]), .flush(flush[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_data(out_data[0]), .occupancy(occupancy[0]), .stall_cnt(sc0));

  ysyx_22040632_pipe_slice #(.DW(64), .DEPTH(2), .BUBBLE(64'h0), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst[1]), .flush(flush[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_data(out_data[1]), .occupancy(occupancy[1]), .stall_cnt(sc1));

  ysyx_22040632_pipe_slice #(.DW(64), .DEPTH(1), .BUBBLE(BUB), .CNT_W(8)) u_single (
    .clk(clk), .rst(rst[2]), .flush(flush[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(in_data[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_data(out_data[2]), .occupancy(occupancy[2]), .stall_cnt(sc2));

  int          checks;
  int          errors;
  int          cu;
  logic [63:0] mq[$];
  int unsigned mcnt;

  function automatic int depth_of(int u);
    return (u == 2) ? 1 : 2;
  endfunction

  function automatic logic [63:0] bubble_of(int u);
    return (u == 1) ? 64'h0 : BUB;
  endfunction

  function automatic int unsigned cmax_of(int u);
    case (u)
      0:       return 32'hFFFF_FFFF;
      1:       return 15;
      default: return 255;
    endcase
  endfunction

  // Reference model: a FIFO of at most DEPTH entries.
  function automatic logic m_in_ready();
    if (rst[cu]) return 1'b0;
    if (depth_of(cu) == 1) return (mq.size() == 0) || out_ready[cu];
    return mq.size() < 2;
  endfunction

  function automatic view_t model_view();
    view_t v;
    v.ir  = m_in_ready();
    v.ov  = !rst[cu] && (mq.size() != 0);
    v.od  = v.ov ? mq[0] : bubble_of(cu);
    v.occ = rst[cu] ? 2'd0 : 2'(mq.size());
    v.sc  = mcnt;
    return v;
  endfunction

  function automatic view_t dut_view();
    view_t v;
    v.ir  = in_ready[cu];
    v.ov  = out_valid[cu];
    v.od  = out_data[cu];
    v.occ = occupancy[cu];
    case (cu)
      0:       v.sc = sc0;
      1:       v.sc = {28'h0, sc1};
      default: v.sc = {24'h0, sc2};
    endcase
    return v;
  endfunction

  function automatic string fmt(view_t v);
    return $sformatf("ir=%b ov=%b od=%h occ=%0d sc=%0d", v.ir, v.ov, v.od, v.occ, v.sc);
  endfunction

  // Called just after a negedge: advance the model over the next rising edge.
  task automatic tick();
    logic ov, inf, outf;
    ov   = !rst[cu] && (mq.size() != 0);
    inf  = in_valid[cu] && m_in_ready();
    outf = ov && out_ready[cu];
    if (rst[cu]) begin
      mq.delete();
      mcnt = 0;
    end else begin
      if (ov && !out_ready[cu] && mcnt < cmax_of(cu)) mcnt++;
      if (flush[cu]) begin
        mq.delete();
      end else begin
        if (outf) void'(mq.pop_front());
        if (inf) mq.push_back(in_data[cu]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(int u);
    cu           = u;
    in_valid[u]  = 1'b0;
    out_ready[u] = 1'b0;
    flush[u]     = 1'b0;
    in_data[u]   = '0;
    rst[u]       = 1'b1;
    @(negedge clk);
    tick();
    rst[u] = 1'b0;
  endtask

  task automatic test_reset();
    cu           = 0;
    rst[0]       = 1'b1;
    in_valid[0]  = 1'b1;
    in_data[0]   = 64'hDEAD;
    out_ready[0] = 1'b0;
    flush[0]     = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (dut_view() !== model_view()) begin
        errors++;
        $display("FAIL reset_model[%0d] got %s want %s", i, fmt(dut_view()), fmt(model_view()));
      end
      checks++;
      if (in_ready[0] !== 1'b0 || out_valid[0] !== 1'b0 || out_data[0] !== BUB) begin
        errors++;
        $display("FAIL reset_hold[%0d] got ir=%b ov=%b od=%h want ir=0 ov=0 od=%h",
                 i, in_ready[0], out_valid[0], out_data[0], BUB);
      end
      tick();
    end
    rst[0]      = 1'b0;
    in_valid[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL reset_release got in_ready=%b want 1", in_ready[0]);
    end
    tick();
  endtask

  task automatic test_stream(int u);
    logic [63:0] got[$];
    int first_out = -1;
    int last_out  = -1;
    do_reset(u);
    out_ready[u] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_valid[u] = (i < 8);
      in_data[u]  = 64'(i + 1);
      @(negedge clk);
      checks++;
      if (dut_view() !== model_view()) begin
        errors++;
        $display("FAIL stream_u%0d[%0d] got %s want %s", u, i, fmt(dut_view()), fmt(model_view()));
      end
      checks++;
      if (occupancy[u] > 2'd1) begin
        errors++;
        $display("FAIL stream_occ_u%0d[%0d] got %0d want <=1", u, i, occupancy[u]);
      end
      if (out_valid[u] && out_ready[u]) begin
        if (first_out < 0) first_out = i;
        last_out = i;
        got.push_back(out_data[u]);
      end
      tick();
    end
    in_valid[u] = 1'b0;
    checks++;
    if (first_out != 1 || last_out != 8 || got.size() != 8) begin
      errors++;
      $display("FAIL stream_timing_u%0d got first=%0d last=%0d n=%0d want 1 8 8",
               u, first_out, last_out, got.size());
    end
    for (int k = 0; k < got.size(); k++) begin
      checks++;
      if (got[k] !== 64'(k + 1)) begin
        errors++;
        $display("FAIL stream_order_u%0d[%0d] got %h want %h", u, k, got[k], 64'(k + 1));
      end
    end
  endtask

  task automatic test_backpressure(int u);
    logic [63:0] got[$];
    int k = 0;
    logic fire;
    do_reset(u);
    out_ready[u] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid[u] = (k < 2);
      in_data[u]  = (k == 0) ? VA : VB;
      @(negedge clk);
      checks++;
      if (dut_view() !== model_view()) begin
        errors++;
        $display("FAIL bp_fill_u%0d[%0d] got %s want %s", u, i, fmt(dut_view()), fmt(model_view()));
      end
      if (i == 5) begin
        checks++;
        if (occupancy[u] !== 2'(depth_of(u)) || in_ready[u] !== 1'b0) begin
          errors++;
          $display("FAIL bp_full_u%0d got occ=%0d ir=%b want occ=%0d ir=0",
                   u, occupancy[u], in_ready[u], depth_of(u));
        end
      end
      fire = in_valid[u] && m_in_ready();
      tick();
      if (fire) k++;
    end
    out_ready[u] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid[u] = (k < 2);
      in_data[u]  = (k == 0) ? VA : VB;
      @(negedge clk);
      checks++;
      if (dut_view() !== model_view()) begin
        errors++;
        $display("FAIL bp_drain_u%0d[%0d] got %s want %s", u, i, fmt(dut_view()), fmt(model_view()));
      end
      if (out_valid[u]) got.push_back(out_data[u]);
      fire = in_valid[u] && m_in_ready();
      tick();
      if (fire) k++;
    end
    in_valid[u] = 1'b0;
    checks++;
    if (got.size() != 2 || got[0] !== VA || got[1] !== VB) begin
      errors++;
      $display("FAIL bp_order_u%0d got n=%0d first=%h want A then B", u, got.size(),
               (got.size() > 0) ? got[0] : 64'hX);
    end
  endtask

  task automatic test_flush();
    int seen_c = 0;
    do_reset(0);
    for (int i = 0; i < 8; i++) begin
      in_valid[0] = 1'b0; flush[0] = 1'b0; out_ready[0] = 1'b0; in_data[0] = '0;
      case (i)
        0: begin in_valid[0] = 1'b1; in_data[0] = VA; end
        1: begin in_valid[0] = 1'b1; in_data[0] = VB; end
        2: begin in_valid[0] = 1'b1; in_data[0] = VC; flush[0] = 1'b1; end
        3: out_ready[0] = 1'b1;
        4: begin in_valid[0] = 1'b1; in_data[0] = VD; end
        5: begin in_valid[0] = 1'b1; in_data[0] = VC; flush[0] = 1'b1; end
        default: out_ready[0] = 1'b1;
      endcase
      @(negedge clk);
      checks++;
      if (dut_view() !== model_view()) begin
        errors++;
        $display("FAIL flush[%0d] got %s want %s", i, fmt(dut_view()), fmt(model_view()));
      end
      if (out_valid[0] && out_data[0] === VC) seen_c++;
      if (i == 2 || i == 5) begin
        checks++;
        if (in_ready[0] !== (i == 5)) begin
          errors++;
          $display("FAIL flush_ready[%0d] got %b want %b", i, in_ready[0], (i == 5));
        end
      end
      if (i == 3 || i == 6) begin
        checks++;
        if (out_valid[0] !== 1'b0 || occupancy[0] !== 2'd0 || out_data[0] !== BUB) begin
          errors++;
          $display("FAIL flush_empty[%0d] got ov=%b occ=%0d od=%h want 0 0 %h",
                   i, out_valid[0], occupancy[0], out_data[0], BUB);
        end
      end
      tick();
    end
    checks++;
    if (seen_c != 0) begin
      errors++;
      $display("FAIL flush_leak got %0d cycles showing 0xC want 0", seen_c);
    end
  endtask

  task automatic test_flush_pop();
    do_reset(0);
    for (int i = 0; i < 6; i++) begin
      in_valid[0] = (i < 2); in_data[0] = (i == 0) ? VA : VB;
      flush[0] = (i == 2); out_ready[0] = (i >= 2);
      @(negedge clk);
      checks++;
      if (dut_view() !== model_view()) begin
        errors++;
        $display("FAIL flush_pop[%0d] got %s want %s", i, fmt(dut_view()), fmt(model_view()));
      end
      if (i == 2) begin
        checks++;
        if (out_valid[0] !== 1'b1 || out_data[0] !== VA) begin
          errors++;
          $display("FAIL flush_pop_deliver got ov=%b od=%h want ov=1 od=%h", out_valid[0], out_data[0], VA);
        end
      end
      if (i > 2) begin
        checks++;
        if (out_valid[0] !== 1'b0 || occupancy[0] !== 2'd0) begin
          errors++;
          $display("FAIL flush_pop_empty[%0d] got ov=%b occ=%0d want 0 0", i, out_valid[0], occupancy[0]);
        end
      end
      tick();
    end
    flush[0] = 1'b0; out_ready[0] = 1'b0;
  endtask

  task automatic test_saturation();
    do_reset(1);
    for (int i = 0; i < 23; i++) begin
      in_valid[1] = (i == 0); in_data[1] = 64'h5A; out_ready[1] = 1'b0;
      flush[1] = (i == 22);
      @(negedge clk);
      checks++;
      if (dut_view() !== model_view()) begin
        errors++;
        $display("FAIL sat[%0d] got %s want %s", i, fmt(dut_view()), fmt(model_view()));
      end
      tick();
    end
    flush[1] = 1'b0;
    @(negedge clk);
    checks++;
    if (sc1 !== 4'd15 || out_valid[1] !== 1'b0) begin
      errors++;
      $display("FAIL sat_hold got cnt=%0d ov=%b want cnt=15 ov=0", sc1, out_valid[1]);
    end
    tick();
  endtask

  task automatic test_random(int u);
    do_reset(u);
    for (int i = 0; i < 300; i++) begin
      in_valid[u]  = ($urandom % 4) != 0;
      in_data[u]   = {$urandom, $urandom};
      out_ready[u] = ($urandom % 3) != 0;
      flush[u]     = ($urandom % 25) == 0;
      rst[u]       = ($urandom % 97) == 0;
      @(negedge clk);
      checks++;
      if (dut_view() !== model_view()) begin
        errors++;
        $display("FAIL random_u%0d[%0d] got %s want %s", u, i, fmt(dut_view()), fmt(model_view()));
      end
      tick();
    end
    in_valid[u] = 1'b0; out_ready[u] = 1'b0; flush[u] = 1'b0; rst[u] = 1'b0;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    cu        = 0;
    mcnt      = 0;
    rst       = '1;
    flush     = '0;
    in_valid  = '0;
    out_ready = '0;
    in_data   = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = '0;

    test_reset();
    test_stream(0);
    test_backpressure(0);
    test_flush();
    test_flush_pop();
    test_saturation();
    test_stream(2);
    test_backpressure(2);
    test_random(0);
    test_random(1);
    test_random(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
